syndrome_gen: RTL and testbench

Bit-serial BCH syndrome generator for the decoder front end. It accepts one received hard bit per cycle, MSB (highest-degree coefficient r[n-1]) first. For each frame it evaluates the odd syndromes S1, S3, S5 and S7 over the code's Galois field and presents them with a one-cycle valid. Its outputs are the syndrome/valid inputs of the early-stop checker and of the error-locator stage.

---
 rtl/syndrome_gen.sv | 149 ++++++++++++++
 tb/tb_syndrome_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_gen.sv
// Bit-serial BCH syndrome generator: Horner-evaluates S1, S3, S5, S7 of a
// received frame over GF(2^6), GF(2^8) or GF(2^10), MSB coefficient first.
module syndrome_gen (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_code,
    input  logic        i_start,
    input  logic        i_bit,
    input  logic        i_bit_valid,
    output logic [9:0]  o_S1,
    output logic [9:0]  o_S3,
    output logic [9:0]  o_S5,
    output logic [9:0]  o_S7,
    output logic        o_valid,
    output logic        o_busy
);

    localparam int unsigned SW = 10;
    localparam int unsigned CW = 10;

    localparam logic [1:0] CODE_M6  = 2'b00;
    localparam logic [1:0] CODE_M8  = 2'b01;
    localparam logic [1:0] CODE_M10 = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t          state_q;
    logic [1:0]      code_q;
    logic [CW-1:0]   cnt_q;
    logic [SW-1:0]   s1_q, s3_q, s5_q, s7_q;

    logic [SW-1:0]   s1_nxt, s3_nxt, s5_nxt, s7_nxt;
    logic [CW-1:0]   last_idx;
    logic [1:0]      code_in;

    // Multiply by alpha once: shift left and fold the overflow bit back
    // through the primitive polynomial of the selected field.
    function automatic logic [SW-1:0] mul_a(input logic [SW-1:0] x, input logic [1:0] code);
        logic [SW-1:0] y;
        case (code)
            CODE_M8:  y = {2'b00, x[6:0], 1'b0} ^ (x[7] ? 10'h01D : 10'h000);
            CODE_M10: y = {x[8:0], 1'b0}        ^ (x[9] ? 10'h009 : 10'h000);
            default:  y = {4'b0000, x[4:0], 1'b0} ^ (x[5] ? 10'h003 : 10'h000);
        endcase
        return y;
    endfunction

    // Multiply by alpha^k (k <= 7) as a chain of single-step networks.
    function automatic logic [SW-1:0] mul_apow(input logic [SW-1:0] x, input logic [1:0] code,
                                               input int unsigned k);
        logic [SW-1:0] y;
        y = x;
        for (int unsigned i = 0; i < 7; i++) begin
            if (i < k) y = mul_a(y, code);
        end
        return y;
    endfunction

    // Reserved code 11 behaves as the GF(2^6) code.
    assign code_in = (i_code == 2'b11) ? CODE_M6 : i_code;

    always_comb begin
        s1_nxt = mul_apow(s1_q, code_q, 1) ^ SW'(i_bit);
        s3_nxt = mul_apow(s3_q, code_q, 3) ^ SW'(i_bit);
        s5_nxt = '0;
        s7_nxt = '0;
        if (code_q == CODE_M10) begin
            s5_nxt = mul_apow(s5_q, code_q, 5) ^ SW'(i_bit);
            s7_nxt = mul_apow(s7_q, code_q, 7) ^ SW'(i_bit);
        end
    end

    always_comb begin
        case (code_q)
            CODE_M8:  last_idx = CW'(254);
            CODE_M10: last_idx = CW'(1022);
            default:  last_idx = CW'(62);
        endcase
    end

    // Frame control, counters and accumulators share one sequential block.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            code_q  <= CODE_M6;
            cnt_q   <= '0;
            s1_q    <= '0;
            s3_q    <= '0;
            s5_q    <= '0;
            s7_q    <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    o_busy <= 1'b0;
                    state_q <= IDLE;
                    if (i_start) begin
                        state_q <= ACCUM;
                        o_busy  <= 1'b1;
                        code_q  <= code_in;
                        cnt_q   <= '0;
                        s1_q    <= '0;
                        s3_q    <= '0;
                        s5_q    <= '0;
                        s7_q    <= '0;
                    end
                end
                ACCUM: begin
                    if (i_start) begin
                        // Abort: restart with a freshly sampled code.
                        code_q <= code_in;
                        cnt_q  <= '0;
                        s1_q   <= '0;
                        s3_q   <= '0;
                        s5_q   <= '0;
                        s7_q   <= '0;
                    end else if (i_bit_valid) begin
                        s1_q  <= s1_nxt;
                        s3_q  <= s3_nxt;
                        s5_q  <= s5_nxt;
                        s7_q  <= s7_nxt;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == last_idx) begin
                            state_q <= DONE;
                            o_valid <= 1'b1;
                            o_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_S1 = s1_q;
    assign o_S3 = s3_q;
    assign o_S5 = s5_q;
    assign o_S7 = s7_q;

endmodule

// File: tb/tb_syndrome_gen.sv
// Self-checking bench for syndrome_gen: directed and random frames compared
// against a direct polynomial-evaluation model of the syndromes.
module tb_syndrome_gen;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [1:0] i_code;
    logic       i_start;
    logic       i_bit;
    logic       i_bit_valid;
    logic [9:0] o_S1, o_S3, o_S5, o_S7;
    logic       o_valid;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    bit         rx [1023];
    logic [9:0] pow_tab [1023];
    logic [9:0] exp_s [4];

    syndrome_gen dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_code      (i_code),
        .i_start     (i_start),
        .i_bit       (i_bit),
        .i_bit_valid (i_bit_valid),
        .o_S1        (o_S1),
        .o_S3        (o_S3),
        .o_S5        (o_S5),
        .o_S7        (o_S7),
        .o_valid     (o_valid),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_code(input logic [1:0] code);
        return (code == 2'b11) ? 0 : int'(code);
    endfunction

    function automatic int m_of(input logic [1:0] code);
        case (eff_code(code))
            1:       return 8;
            2:       return 10;
            default: return 6;
        endcase
    endfunction

    // Reference: S_j = r(alpha^j) = XOR of alpha^(i*j) over set coefficients r_i.
    task automatic model(input logic [1:0] code);
        int m, n, poly, x;
        int js [4];
        js = '{1, 3, 5, 7};
        m = m_of(code);
        n = (1 << m) - 1;
        poly = (m == 6) ? 'h43 : (m == 8) ? 'h11D : 'h409;
        x = 1;
        for (int e = 0; e < n; e++) begin
            pow_tab[e] = 10'(x);
            x = x << 1;
            if (((x >> m) & 1) != 0) x = x ^ poly;
        end
        for (int k = 0; k < 4; k++) begin
            logic [9:0] acc;
            acc = '0;
            if (k < 2 || eff_code(code) == 2) begin
                for (int t = 0; t < n; t++) begin
                    if (rx[t]) acc = acc ^ pow_tab[((n - 1 - t) * js[k]) % n];
                end
            end
            exp_s[k] = acc;
        end
    endtask

    task automatic clear_rx();
        for (int t = 0; t < 1023; t++) rx[t] = 1'b0;
    endtask

    task automatic random_rx();
        for (int t = 0; t < 1023; t++) rx[t] = 1'($urandom);
    endtask

    // Starts a frame, streams n bits (with optional gaps) and stops in the DONE cycle.
    task automatic send_frame(input logic [1:0] code, input int gap_pct, input bit valid_on_start);
        int n, sent, cycles, early;
        n = (1 << m_of(code)) - 1;
        model(code);
        i_code      = code;
        i_start     = 1'b1;
        i_bit_valid = valid_on_start;
        i_bit       = 1'($urandom);
        tick();
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 32'd1);
        check("s1_cleared", 32'(o_S1), 32'd0);
        sent = 0;
        cycles = 0;
        early = 0;
        while (sent < n && cycles < 4 * n + 64) begin
            i_code = 2'($urandom);
            if (int'($urandom_range(99)) < gap_pct) begin
                i_bit_valid = 1'b0;
                i_bit       = 1'($urandom);
            end else begin
                i_bit_valid = 1'b1;
                i_bit       = rx[sent];
            end
            tick();
            cycles++;
            if (i_bit_valid) sent++;
            if (sent < n && o_valid) early++;
        end
        i_bit_valid = 1'b0;
        check("frame_budget", 32'(sent), 32'(n));
        check("no_early_valid", 32'(early), 32'd0);
        if (gap_pct == 0) check("gapless_latency", 32'(cycles), 32'(n));
        check("valid_pulse", 32'(o_valid), 32'd1);
        check("busy_in_done", 32'(o_busy), 32'd0);
        check("S1", 32'(o_S1), 32'(exp_s[0]));
        check("S3", 32'(o_S3), 32'(exp_s[1]));
        check("S5", 32'(o_S5), 32'(exp_s[2]));
        check("S7", 32'(o_S7), 32'(exp_s[3]));
    endtask

    task automatic idle_after();
        tick();
        check("valid_one_cycle", 32'(o_valid), 32'd0);
        check("busy_idle", 32'(o_busy), 32'd0);
        check("S1_hold", 32'(o_S1), 32'(exp_s[0]));
        check("S7_hold", 32'(o_S7), 32'(exp_s[3]));
    endtask

    task automatic feed_partial(input logic [1:0] code, input int cnt);
        int early;
        early = 0;
        i_code  = code;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int t = 0; t < cnt; t++) begin
            i_bit_valid = 1'b1;
            i_bit       = rx[t];
            tick();
            if (o_valid) early++;
        end
        i_bit_valid = 1'b0;
        check("partial_no_valid", 32'(early), 32'd0);
    endtask

    initial begin
        int spurious;
        i_rst_n     = 1'b0;
        i_code      = 2'b00;
        i_start     = 1'b0;
        i_bit       = 1'b0;
        i_bit_valid = 1'b0;
        tick();
        tick();
        check("rst_S1", 32'(o_S1), 32'd0);
        check("rst_S3", 32'(o_S3), 32'd0);
        check("rst_S5", 32'(o_S5), 32'd0);
        check("rst_S7", 32'(o_S7), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        i_rst_n = 1'b1;
        tick();

        clear_rx();
        send_frame(2'b10, 0, 1'b0);
        check("zero_S1", 32'(o_S1), 32'h000);
        idle_after();

        clear_rx();
        rx[62] = 1'b1;
        send_frame(2'b00, 0, 1'b0);
        check("r0_m6_S1", 32'(o_S1), 32'h001);
        check("r0_m6_S3", 32'(o_S3), 32'h001);
        check("r0_m6_S5", 32'(o_S5), 32'h000);
        idle_after();

        clear_rx();
        rx[1022] = 1'b1;
        send_frame(2'b10, 0, 1'b0);
        check("r0_m10_S5", 32'(o_S5), 32'h001);
        check("r0_m10_S7", 32'(o_S7), 32'h001);
        idle_after();

        clear_rx();
        rx[1021] = 1'b1;
        send_frame(2'b10, 0, 1'b0);
        check("r1_m10_S1", 32'(o_S1), 32'h002);
        check("r1_m10_S3", 32'(o_S3), 32'h008);
        check("r1_m10_S5", 32'(o_S5), 32'h020);
        check("r1_m10_S7", 32'(o_S7), 32'h080);
        idle_after();

        clear_rx();
        rx[1012] = 1'b1;
        send_frame(2'b10, 0, 1'b0);
        check("r10_m10_S1", 32'(o_S1), 32'h009);
        idle_after();

        clear_rx();
        rx[61] = 1'b1;
        send_frame(2'b00, 0, 1'b0);
        check("r1_m6_S1", 32'(o_S1), 32'h002);
        check("r1_m6_S3", 32'(o_S3), 32'h008);
        idle_after();

        random_rx();
        send_frame(2'b01, 30, 1'b1);
        idle_after();

        // Back-to-back random frames: each new start lands in the DONE cycle.
        for (int f = 0; f < 5; f++) begin
            random_rx();
            send_frame(2'($urandom), 20, 1'($urandom));
        end
        idle_after();

        random_rx();
        feed_partial(2'b10, 500);
        send_frame(2'b00, 0, 1'b0);
        check("abort_S5", 32'(o_S5), 32'h000);
        check("abort_S7", 32'(o_S7), 32'h000);
        idle_after();

        random_rx();
        feed_partial(2'b10, 300);
        i_rst_n = 1'b0;
        tick();
        check("midrst_S1", 32'(o_S1), 32'd0);
        check("midrst_S3", 32'(o_S3), 32'd0);
        check("midrst_S5", 32'(o_S5), 32'd0);
        check("midrst_S7", 32'(o_S7), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        i_rst_n = 1'b1;
        spurious = 0;
        for (int t = 0; t < 1100; t++) begin
            i_bit_valid = 1'b1;
            i_bit       = 1'($urandom);
            tick();
            if (o_valid || o_busy) spurious++;
        end
        i_bit_valid = 1'b0;
        check("midrst_quiet", 32'(spurious), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
